cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Hardwired Moore control sequencer for the single-bus RISC datapath.
- Steps the datapath through fetch (T0–T2) and per-opcode execute steps (T3–T7) by driving its enable, bus-out, memory and ALU-opcode signals.
- Register selection goes through separate select-and-encode logic, which this block controls via Gra/Grb/Grc/Rin/Rout/BAout.
- Supports memory wait states and a halt/stop mechanism.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- ADD_OP, 5'b00011, ALU opcode used for address/immediate/branch-target adds.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- ir  in  32  current instruction register contents.
- con_ff  in  1  branch condition flip-flop output.
- mem_rdy  in  1  memory done; 1 = current Read/Write completes this cycle.
- stop  in  1  request halt at the next instruction boundary.
- PC_enable, IncPC, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable, HI_enable, LO_enable, CON_enable  out  1 each  register load strobes.
- PCout, MDRout, ZLowout, ZHighout, HIout, LOout, Cout  out  1 each  bus drivers.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select-and-encode controls.
- Read, Write  out  1 each  memory strobes.
- alu_op  out  5  ALU opcode.
- run  out  1  1 = executing, 0 = reset or halted.

Behaviour:
- State encoding: RESET, T0..T7, HALT. All outputs are decoded from state and ir only.
- Default output is 0 for any signal not listed for a step. alu_op = 0 unless listed.
- While clr=1: state=RESET, all outputs 0, run=0.
- Leaving reset: first edge after clr falls moves RESET->T0. run=1 in T0–T7.
- Fetch steps:
  - T0: PCout, MAR_enable, IncPC, PC_enable.
  - T1: Read, MDR_enable. Hold T1 until mem_rdy=1.
  - T2: MDRout, IR_enable.
- Execute steps by ir[31:27]; after the last listed step, next state is T0:
  - Reg-reg ALU ops (add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010):
    - T3 Grb Rout Y_enable; T4 Grc Rout alu_op=opcode Z_enable; T5 ZLowout Gra Rin.
  - addi 01011, andi 01100, ori 01101:
    - T3 Grb Rout Y_enable; T4 Cout alu_op=(add/and/or code) Z_enable; T5 ZLowout Gra Rin.
  - neg 10000, not 10001:
    - T3 Grb Rout alu_op=opcode Z_enable; T4 ZLowout Gra Rin.
  - mul 01110, div 01111:
    - T3 Gra Rout Y_enable; T4 Grb Rout alu_op=opcode Z_enable; T5 ZLowout LO_enable; T6 ZHighout HI_enable.
  - ldi 00001:
    - T3 Grb BAout Y_enable; T4 Cout alu_op=ADD_OP Z_enable; T5 ZLowout Gra Rin.
  - ld 00000:
    - T3–T4 as ldi; T5 ZLowout MAR_enable; T6 Read MDR_enable (hold until mem_rdy); T7 MDRout Gra Rin.
  - st 00010:
    - T3–T5 as ld; T6 Gra Rout MDR_enable (Read=0); T7 Write (hold until mem_rdy).
  - branch 10010:
    - T3 Gra Rout CON_enable; T4 PCout Y_enable; T5 Cout alu_op=ADD_OP Z_enable; T6 ZLowout PC_enable only if con_ff=1, else no strobes.
  - jr 10011: T3 Gra Rout PC_enable.
  - mfhi 10111: T3 HIout Gra Rin. mflo 11000: T3 LOout Gra Rin.
  - halt 11010: T3 with no strobes, then ->HALT.
  - All other opcodes (incl. nop 11001): T3 with no strobes, then ->T0.
- Wait-state rule: all outputs stay stable while holding for mem_rdy. mem_rdy is ignored in non-memory steps.
- stop: sampled on the last execute step. stop=1 -> HALT instead of T0. A stop pulse during fetch or earlier steps is not latched.
- HALT: all outputs 0, run=0. Exit only via clr.
- clr mid-instruction aborts immediately (async) with no partial strobes. Execution restarts at T0.

Optional Feature:
- CU_SINGLE_STEP_EN defined: adds input step (1 bit) and state WAIT.
  - After each instruction's last step, go to WAIT: outputs 0, run=1.
  - Leave WAIT to T0 on the first cycle step=1. stop has priority: WAIT + stop=1 -> HALT.
- Undefined: no step port, no WAIT state; free-running.

Test Plan:
- clr=1 mid-T4 of add -> all outputs 0, run=0 immediately; one cycle after release, T0 asserts PCout=MAR_enable=IncPC=PC_enable=1.
- ir=add r3,r1,r2 (0x19888000), mem_rdy=1 -> T0–T5 in 6 cycles; T4 alu_op=00011 with Grc/Rout/Z_enable; T5 ZLowout/Gra/Rin.
- ld (opcode 00000) with mem_rdy held 0 for 3 cycles in T6 -> Read=MDR_enable=1 for 4 cycles, then T7 MDRout/Gra/Rin; total 11 cycles.
- branch with con_ff=0 -> T6 has PC_enable=0. Same instruction with con_ff=1 -> T6 ZLowout=PC_enable=1.
- mul -> T5 LO_enable/ZLowout, T6 HI_enable/ZHighout; stop=1 at T6 -> HALT, run=0, held 20 cycles.
- halt opcode 11010 -> HALT after T3. Opcode 11111 -> T3 with no strobes, then back to T0.

Source files
------------

// File: rtl/cpu_control_unit.sv
// ---------------------------------------------------------------------------
// cpu_control_unit
//
// Hardwired Moore control sequencer for a single-bus RISC datapath. It walks
// the datapath through a three-step fetch (T0-T2) followed by up to five
// execute steps (T3-T7) chosen by the opcode in ir[31:27]. Register selection
// is delegated to an external select-and-encode block through
// Gra/Grb/Grc/Rin/Rout/BAout.
//
// Optional build macro: CU_SINGLE_STEP_EN
//   Adds the `step` input and a WAIT state entered after every instruction.
//   WAIT holds all strobes low with run=1 and leaves to T0 on step=1;
//   stop=1 in WAIT goes to HALT instead.
//
// Ports
//   clk, clr          clock; asynchronous active-high reset
//   ir                instruction register contents (opcode = ir[31:27])
//   con_ff            branch condition flip-flop
//   mem_rdy           memory completes the current Read/Write this cycle
//   stop              halt request, honoured at the instruction boundary
//   step              (CU_SINGLE_STEP_EN only) release WAIT
//   *_enable, IncPC   register load strobes
//   *out, Cout        bus drivers
//   Gra..BAout        select-and-encode controls
//   Read, Write       memory strobes
//   alu_op            ALU opcode
//   run               1 while executing (T0-T7, and WAIT)
//   dbg_state_o       current sequencer state, for observation only
//
// Memory handshake: Read (T1, ld T6) or Write (st T7) is held together with
// every other output of that step until a cycle with mem_rdy=1; the step
// completes on that cycle's rising edge. mem_rdy is ignored in other steps.
// ---------------------------------------------------------------------------
module cpu_control_unit #(
    parameter int             OPW    = 5,
    parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [31:0]    ir,
    input  logic           con_ff,
    input  logic           mem_rdy,
    input  logic           stop,
`ifdef CU_SINGLE_STEP_EN
    input  logic           step,
`endif
    output logic           PC_enable,
    output logic           IncPC,
    output logic           IR_enable,
    output logic           MAR_enable,
    output logic           MDR_enable,
    output logic           Y_enable,
    output logic           Z_enable,
    output logic           HI_enable,
    output logic           LO_enable,
    output logic           CON_enable,
    output logic           PCout,
    output logic           MDRout,
    output logic           ZLowout,
    output logic           ZHighout,
    output logic           HIout,
    output logic           LOout,
    output logic           Cout,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic           Read,
    output logic           Write,
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic [3:0]     dbg_state_o
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
        S_HALT
`ifdef CU_SINGLE_STEP_EN
        , S_WAIT
`endif
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_AND  = 5'b01001;
    localparam logic [OPW-1:0] OP_OR   = 5'b01010;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JR   = 5'b10011;
    localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPW-1:0] OP_HALT = 5'b11010;

    state_t         state_q, state_d;
    state_t         last_step;
    logic [OPW-1:0] opcode;
    logic           is_rr, is_imm, is_un, is_md, is_addr;
    logic           mem_wait;

    assign opcode = ir[31 -: OPW];

    // Opcode classes sharing the same execute-step skeleton.
    assign is_rr   = (opcode >= 5'b00011) && (opcode <= 5'b01010);
    assign is_imm  = (opcode >= 5'b01011) && (opcode <= 5'b01101);
    assign is_un   = (opcode == 5'b10000) || (opcode == 5'b10001);
    assign is_md   = (opcode == 5'b01110) || (opcode == 5'b01111);
    assign is_addr = (opcode == OP_LDI) || (opcode == OP_LD) || (opcode == OP_ST);

    // Steps that carry a memory strobe stall until mem_rdy.
    assign mem_wait = !mem_rdy &&
                      ((state_q == S_T1) ||
                       (state_q == S_T6 && opcode == OP_LD) ||
                       (state_q == S_T7 && opcode == OP_ST));

    // Final execute step of the current opcode; stop is sampled here.
    always_comb begin
        last_step = S_T3;
        if (is_rr || is_imm || opcode == OP_LDI) last_step = S_T5;
        else if (is_un)                          last_step = S_T4;
        else if (is_md || opcode == OP_BR)       last_step = S_T6;
        else if (opcode == OP_LD || opcode == OP_ST) last_step = S_T7;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (!mem_wait) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_HALT:  state_d = S_HALT;
`ifdef CU_SINGLE_STEP_EN
            S_WAIT: begin
                if (stop)      state_d = S_HALT;
                else if (step) state_d = S_T0;
            end
`endif
            default: begin
                if (mem_wait) begin
                    state_d = state_q;
                end else if (state_q == last_step) begin
                    if (opcode == OP_HALT || stop) state_d = S_HALT;
`ifdef CU_SINGLE_STEP_EN
                    else                           state_d = S_WAIT;
`else
                    else                           state_d = S_T0;
`endif
                end else begin
                    case (state_q)
                        S_T3:    state_d = S_T4;
                        S_T4:    state_d = S_T5;
                        S_T5:    state_d = S_T6;
                        S_T6:    state_d = S_T7;
                        default: state_d = S_T0;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        PC_enable = 1'b0; IncPC = 1'b0; IR_enable = 1'b0; MAR_enable = 1'b0;
        MDR_enable = 1'b0; Y_enable = 1'b0; Z_enable = 1'b0; HI_enable = 1'b0;
        LO_enable = 1'b0; CON_enable = 1'b0;
        PCout = 1'b0; MDRout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Cout = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        Read = 1'b0; Write = 1'b0;
        alu_op = '0;
        run = 1'b0;

        case (state_q)
            S_T0: begin
                PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; PC_enable = 1'b1;
            end
            S_T1: begin
                Read = 1'b1; MDR_enable = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IR_enable = 1'b1;
            end
            S_T3: begin
                if (is_rr || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
                end else if (is_un) begin
                    Grb = 1'b1; Rout = 1'b1; alu_op = opcode; Z_enable = 1'b1;
                end else if (is_md) begin
                    Gra = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
                end else if (is_addr) begin
                    Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
                end else if (opcode == OP_BR) begin
                    Gra = 1'b1; Rout = 1'b1; CON_enable = 1'b1;
                end else if (opcode == OP_JR) begin
                    Gra = 1'b1; Rout = 1'b1; PC_enable = 1'b1;
                end else if (opcode == OP_MFHI) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (opcode == OP_MFLO) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T4: begin
                if (is_rr) begin
                    Grc = 1'b1; Rout = 1'b1; alu_op = opcode; Z_enable = 1'b1;
                end else if (is_imm) begin
                    Cout = 1'b1; Z_enable = 1'b1;
                    // Immediate forms reuse the register-form ALU codes.
                    if (opcode == OP_ADDI)      alu_op = ADD_OP;
                    else if (opcode == OP_ANDI) alu_op = OP_AND;
                    else                        alu_op = OP_OR;
                end else if (is_un) begin
                    ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_md) begin
                    Grb = 1'b1; Rout = 1'b1; alu_op = opcode; Z_enable = 1'b1;
                end else if (is_addr) begin
                    Cout = 1'b1; alu_op = ADD_OP; Z_enable = 1'b1;
                end else if (opcode == OP_BR) begin
                    PCout = 1'b1; Y_enable = 1'b1;
                end
            end
            S_T5: begin
                if (is_rr || is_imm || opcode == OP_LDI) begin
                    ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_md) begin
                    ZLowout = 1'b1; LO_enable = 1'b1;
                end else if (opcode == OP_LD || opcode == OP_ST) begin
                    ZLowout = 1'b1; MAR_enable = 1'b1;
                end else if (opcode == OP_BR) begin
                    Cout = 1'b1; alu_op = ADD_OP; Z_enable = 1'b1;
                end
            end
            S_T6: begin
                if (is_md) begin
                    ZHighout = 1'b1; HI_enable = 1'b1;
                end else if (opcode == OP_LD) begin
                    Read = 1'b1; MDR_enable = 1'b1;
                end else if (opcode == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDR_enable = 1'b1;
                end else if (opcode == OP_BR && con_ff) begin
                    // Untaken branch leaves PC alone: no strobes at all.
                    ZLowout = 1'b1; PC_enable = 1'b1;
                end
            end
            S_T7: begin
                if (opcode == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (opcode == OP_ST) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase

        case (state_q)
            S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: run = 1'b1;
`ifdef CU_SINGLE_STEP_EN
            S_WAIT: run = 1'b1;
`endif
            default: run = 1'b0;
        endcase
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit (default build). All outputs are packed into
// one 31-bit word; expected words are composed from named output masks.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] ir = 32'd0;
    logic        con_ff = 1'b0, mem_rdy = 1'b1, stop = 1'b0;
    logic PC_enable, IncPC, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable;
    logic HI_enable, LO_enable, CON_enable, PCout, MDRout, ZLowout, ZHighout;
    logic HIout, LOout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, run;
    logic [4:0]  alu_op;
    logic [3:0]  dbg_state;
    logic [30:0] act;

    always #5 clk = ~clk;

    cpu_control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_rdy(mem_rdy), .stop(stop),
        .PC_enable(PC_enable), .IncPC(IncPC), .IR_enable(IR_enable), .MAR_enable(MAR_enable),
        .MDR_enable(MDR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
        .HI_enable(HI_enable), .LO_enable(LO_enable), .CON_enable(CON_enable),
        .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout), .ZHighout(ZHighout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .Read(Read), .Write(Write),
        .alu_op(alu_op), .run(run), .dbg_state_o(dbg_state)
    );

    assign act = {PC_enable, IncPC, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable,
                  HI_enable, LO_enable, CON_enable, PCout, MDRout, ZLowout, ZHighout,
                  HIout, LOout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, Read, Write,
                  alu_op, run};

    localparam logic [30:0] PCEN  = 31'(1) << 30, INCPC = 31'(1) << 29, IREN  = 31'(1) << 28;
    localparam logic [30:0] MAREN = 31'(1) << 27, MDREN = 31'(1) << 26, YEN   = 31'(1) << 25;
    localparam logic [30:0] ZEN   = 31'(1) << 24, HIEN  = 31'(1) << 23, LOEN  = 31'(1) << 22;
    localparam logic [30:0] CONEN = 31'(1) << 21, PCOUT = 31'(1) << 20, MDROUT = 31'(1) << 19;
    localparam logic [30:0] ZLO   = 31'(1) << 18, ZHI   = 31'(1) << 17, HIOUT = 31'(1) << 16;
    localparam logic [30:0] LOOUT = 31'(1) << 15, COUT  = 31'(1) << 14, GRA   = 31'(1) << 13;
    localparam logic [30:0] GRB   = 31'(1) << 12, GRC   = 31'(1) << 11, RIN   = 31'(1) << 10;
    localparam logic [30:0] ROUT  = 31'(1) << 9,  BAOUT = 31'(1) << 8,  READ  = 31'(1) << 7;
    localparam logic [30:0] WRITE = 31'(1) << 6,  R     = 31'(1);
    localparam logic [30:0] F0 = R | PCOUT | MAREN | INCPC | PCEN;
    localparam logic [30:0] F1 = R | READ | MDREN;
    localparam logic [30:0] F2 = R | MDROUT | IREN;

    function automatic logic [30:0] alu(input logic [4:0] c);
        return {25'd0, c, 1'b0};
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [30:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Check the current step at the falling edge, then move past the next rise.
    task automatic step_check(input logic [30:0] exp, input string nm);
        @(negedge clk);
        chk(nm, exp);
        @(posedge clk);
        #1;
    endtask

    // Reference model: the ordered list of per-step output words for one
    // instruction, with a flag marking steps that wait for mem_rdy.
    logic [30:0] exp_q[$];
    bit          mem_q[$];

    task automatic push(input logic [30:0] w, input bit m);
        exp_q.push_back(w);
        mem_q.push_back(m);
    endtask

    task automatic build(input logic [4:0] op, input logic cf);
        exp_q.delete();
        mem_q.delete();
        push(F0, 0); push(F1, 1); push(F2, 0);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
                push(R | GRB | ROUT | YEN, 0);
                push(R | GRC | ROUT | alu(op) | ZEN, 0);
                push(R | ZLO | GRA | RIN, 0);
            end
            5'd11, 5'd12, 5'd13: begin
                push(R | GRB | ROUT | YEN, 0);
                push(R | COUT | ZEN | alu(op == 5'd11 ? 5'd3 : (op == 5'd12 ? 5'd9 : 5'd10)), 0);
                push(R | ZLO | GRA | RIN, 0);
            end
            5'd16, 5'd17: begin
                push(R | GRB | ROUT | alu(op) | ZEN, 0);
                push(R | ZLO | GRA | RIN, 0);
            end
            5'd14, 5'd15: begin
                push(R | GRA | ROUT | YEN, 0);
                push(R | GRB | ROUT | alu(op) | ZEN, 0);
                push(R | ZLO | LOEN, 0);
                push(R | ZHI | HIEN, 0);
            end
            5'd1: begin
                push(R | GRB | BAOUT | YEN, 0);
                push(R | COUT | alu(5'd3) | ZEN, 0);
                push(R | ZLO | GRA | RIN, 0);
            end
            5'd0: begin
                push(R | GRB | BAOUT | YEN, 0);
                push(R | COUT | alu(5'd3) | ZEN, 0);
                push(R | ZLO | MAREN, 0);
                push(R | READ | MDREN, 1);
                push(R | MDROUT | GRA | RIN, 0);
            end
            5'd2: begin
                push(R | GRB | BAOUT | YEN, 0);
                push(R | COUT | alu(5'd3) | ZEN, 0);
                push(R | ZLO | MAREN, 0);
                push(R | GRA | ROUT | MDREN, 0);
                push(R | WRITE, 1);
            end
            5'd18: begin
                push(R | GRA | ROUT | CONEN, 0);
                push(R | PCOUT | YEN, 0);
                push(R | COUT | alu(5'd3) | ZEN, 0);
                push(cf ? (R | ZLO | PCEN) : R, 0);
            end
            5'd19: push(R | GRA | ROUT | PCEN, 0);
            5'd23: push(R | HIOUT | GRA | RIN, 0);
            5'd24: push(R | LOOUT | GRA | RIN, 0);
            default: push(R, 0);
        endcase
    endtask

    typedef struct {
        logic [31:0] ir;
        logic        cf;
        int          len;
        int          chk_step;
        logic [30:0] chk_word;
        logic [30:0] last_word;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{32'h19888000, 1'b0, 6, 4, R | GRC | ROUT | alu(5'd3) | ZEN, R | ZLO | GRA | RIN};
        vecs[1]  = '{32'h60000000, 1'b0, 6, 4, R | COUT | alu(5'd9) | ZEN,       R | ZLO | GRA | RIN};
        vecs[2]  = '{32'h80000000, 1'b0, 5, 3, R | GRB | ROUT | alu(5'd16) | ZEN, R | ZLO | GRA | RIN};
        vecs[3]  = '{32'h70000000, 1'b0, 7, 5, R | ZLO | LOEN,                   R | ZHI | HIEN};
        vecs[4]  = '{32'h08000000, 1'b0, 6, 3, R | GRB | BAOUT | YEN,            R | ZLO | GRA | RIN};
        vecs[5]  = '{32'h10000000, 1'b0, 8, 6, R | GRA | ROUT | MDREN,           R | WRITE};
        vecs[6]  = '{32'h90000000, 1'b0, 7, 5, R | COUT | alu(5'd3) | ZEN,       R};
        vecs[7]  = '{32'h90000000, 1'b1, 7, 3, R | GRA | ROUT | CONEN,           R | ZLO | PCEN};
        vecs[8]  = '{32'h98000000, 1'b0, 4, 3, R | GRA | ROUT | PCEN,            R | GRA | ROUT | PCEN};
        vecs[9]  = '{32'hB8000000, 1'b0, 4, 3, R | HIOUT | GRA | RIN,            R | HIOUT | GRA | RIN};
        vecs[10] = '{32'hC0000000, 1'b0, 4, 3, R | LOOUT | GRA | RIN,            R | LOOUT | GRA | RIN};
        vecs[11] = '{32'hF8000000, 1'b0, 4, 3, R,                                R};
        vecs[12] = '{32'hC8000000, 1'b0, 4, 3, R,                                R};

        // Reset state and release.
        #2;
        chk("reset_outputs", 31'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        step_check(31'd0, "reset_after_release");

        // Table: one instruction per entry, memory always ready.
        for (int i = 0; i < 13; i++) begin
            ir = vecs[i].ir;
            con_ff = vecs[i].cf;
            for (int c = 0; c < vecs[i].len; c++) begin
                @(negedge clk);
                if (c == 0)                chk($sformatf("vec%0d_t0", i), F0);
                if (c == vecs[i].chk_step) chk($sformatf("vec%0d_step%0d", i, c), vecs[i].chk_word);
                if (c == vecs[i].len - 1)  chk($sformatf("vec%0d_last", i), vecs[i].last_word);
                @(posedge clk); #1;
            end
        end
        con_ff = 1'b0;

        // Asynchronous clear in the middle of T4 of an add.
        ir = 32'h19888000;
        step_check(F0, "add_t0"); step_check(F1, "add_t1");
        step_check(F2, "add_t2"); step_check(R | GRB | ROUT | YEN, "add_t3");
        @(negedge clk);
        chk("add_t4", R | GRC | ROUT | alu(5'd3) | ZEN);
        #1 clr = 1'b1;
        #1 chk("clr_abort", 31'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        step_check(31'd0, "clr_reset_state");
        step_check(F0, "t0_after_clr");

        // ld with three memory wait cycles in T6: 11 cycles overall.
        ir = 32'h00000000;
        step_check(F1, "ld_t1"); step_check(F2, "ld_t2");
        step_check(R | GRB | BAOUT | YEN, "ld_t3");
        step_check(R | COUT | alu(5'd3) | ZEN, "ld_t4");
        step_check(R | ZLO | MAREN, "ld_t5");
        mem_rdy = 1'b0;
        for (int k = 0; k < 3; k++) step_check(R | READ | MDREN, $sformatf("ld_t6_wait%0d", k));
        mem_rdy = 1'b1;
        step_check(R | READ | MDREN, "ld_t6_done");
        step_check(R | MDROUT | GRA | RIN, "ld_t7");

        // mul followed by stop sampled on its last step.
        ir = 32'h70000000;
        step_check(F0, "mul_t0"); step_check(F1, "mul_t1"); step_check(F2, "mul_t2");
        step_check(R | GRA | ROUT | YEN, "mul_t3");
        step_check(R | GRB | ROUT | alu(5'd14) | ZEN, "mul_t4");
        step_check(R | ZLO | LOEN, "mul_t5");
        stop = 1'b1;
        step_check(R | ZHI | HIEN, "mul_t6");
        stop = 1'b0;
        for (int k = 0; k < 20; k++) step_check(31'd0, $sformatf("halt_hold%0d", k));

        // halt opcode after a fresh clear.
        clr = 1'b1;
        step_check(31'd0, "clr_from_halt");
        clr = 1'b0;
        step_check(31'd0, "reset_before_halt_op");
        ir = 32'hD0000000;
        step_check(F0, "hlt_t0"); step_check(F1, "hlt_t1"); step_check(F2, "hlt_t2");
        step_check(R, "hlt_t3");
        for (int k = 0; k < 3; k++) step_check(31'd0, $sformatf("hlt_halted%0d", k));
        clr = 1'b1;
        step_check(31'd0, "clr_after_halt_op");
        clr = 1'b0;
        step_check(31'd0, "reset_before_jr");

        // A stop pulse during fetch is not remembered.
        ir = 32'h98000000;
        stop = 1'b1;
        step_check(F0, "jr_t0_stop"); step_check(F1, "jr_t1_stop");
        stop = 1'b0;
        step_check(F2, "jr_t2"); step_check(R | GRA | ROUT | PCEN, "jr_t3");

        // Random instruction stream against the step-list model.
        begin
            int  idx = 0;
            bit  halted = 0;
            logic [4:0] op = 5'd0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (!halted && idx == 0) begin
                    op = 5'($urandom_range(0, 31));
                    ir = {op, 27'($urandom)};
                    con_ff = 1'($urandom_range(0, 1));
                    build(op, con_ff);
                end
                mem_rdy = ($urandom_range(0, 2) != 0);
                stop = ($urandom_range(0, 24) == 0);
                @(negedge clk);
                if (halted) begin
                    chk("rand_halted", 31'd0);
                    @(posedge clk); #1;
                    clr = 1'b1;
                    #1 chk("rand_clr", 31'd0);
                    @(posedge clk); #1;
                    clr = 1'b0;
                    step_check(31'd0, "rand_reset");
                    halted = 0;
                    idx = 0;
                    continue;
                end
                chk($sformatf("rand_op%0d_step%0d", op, idx), exp_q[idx]);
                if (mem_q[idx] && !mem_rdy) begin
                    idx = idx;
                end else if (idx == exp_q.size() - 1) begin
                    idx = 0;
                    if (op == 5'd26 || stop) halted = 1;
                end else begin
                    idx++;
                end
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
